// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB configuration engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sccb_pkg;

    typedef enum logic [3:0] {
        IDLE,
        START,
        TXBIT,
        TXACK,
        RXBIT,
        RXNACK,
        STOP,
        GAP,
        DONE
    } state_e;

    localparam int   BITS_PER_BYTE = 8;
    localparam int   TICKS_PER_BIT = 4;
    localparam logic READ_ID_LSB   = 1'b1;

    // Device ID with the R/W bit forced: 0 for write phases, 1 for the read phase.
    function automatic logic [7:0] id_byte(input logic [7:0] id, input logic rd);
        return {id[7:1], rd ? READ_ID_LSB : 1'b0};
    endfunction

endpackage

// File: rtl/sccb_master_if.sv
// Request/response handshake between the LUT sequencer and the SCCB engine.
// Latency: n/a (wires only).
// Backpressure: sequencer holds iGO until oEND returns high.
interface sccb_master_if;

    logic        iGO;
    logic        iWR;
    logic [23:0] iWDATA;
    logic        oEND;
    logic        oACK;
    logic [7:0]  oRDATA;

    // Sequencer side
    modport master (
        output iGO, iWR, iWDATA,
        input  oEND, oACK, oRDATA
    );

    // Engine side
    modport slave (
        input  iGO, iWR, iWDATA,
        output oEND, oACK, oRDATA
    );

endinterface

// File: rtl/sccb_tick_gen.sv
// Quarter-bit tick generator: one-cycle pulse every QDIV clocks while enabled.
// Latency: first tick QDIV cycles after clr_i drops.
// Backpressure: none; clr_i holds the counter at zero.
module sccb_tick_gen #(
    parameter int QDIV = 62
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = (QDIV > 2) ? $clog2(QDIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          wrap;

    assign wrap   = (cnt_q == CW'(QDIV - 1));
    assign tick_o = wrap && !clr_i;

    // Next count: wrap at QDIV-1, hold at zero while cleared.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr_i || wrap) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sccb_master.sv
// SCCB bit engine: 3-phase write, or 2-phase write then 2-phase read, on open-drain SCL/SDA.
// Latency: 116 quarter-bit ticks per write, 164 per read (4-tick bus-free gap between phases).
// Backpressure: iGO is level; oEND stays high in DONE until iGO drops, so no retrigger.
module sccb_master
    import sccb_pkg::*;
#(
    parameter int CLK_FREQ  = 25_000_000,
    parameter int SCCB_FREQ = 100_000,
    parameter int QDIV      = CLK_FREQ / (4 * SCCB_FREQ)
) (
    input  logic         iCLK,
    input  logic         iRST_N,
    sccb_master_if.slave seq,
    output logic         I2C_SCLK,
    inout  wire          I2C_SDAT
);

    state_e      state_q, state_d;
    logic [1:0]  qtr_q, qtr_d;
    logic [2:0]  bit_q, bit_d;
    logic [1:0]  byte_q, byte_d;
    logic        rdph_q, rdph_d;
    logic        wr_q, wr_d;
    logic [23:0] wdata_q, wdata_d;
    logic [7:0]  rx_q, rx_d;
    logic        scl_q, scl_d;
    logic        oe_q, oe_d;
    logic        end_q, end_d;
    logic        ack_q, ack_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        sda_meta_q, sda_s_q;
    logic        tick;
    logic        last_qtr;
    logic        last_byte;
    logic [7:0]  cur_byte;

    sccb_tick_gen #(.QDIV(QDIV)) u_tick (
        .clk_i   (iCLK),
        .rst_n_i (iRST_N),
        .clr_i   ((state_q == IDLE) || (state_q == DONE)),
        .tick_o  (tick)
    );

    assign I2C_SDAT   = oe_q ? 1'b0 : 1'bz;
    assign I2C_SCLK   = scl_q;
    assign seq.oEND   = end_q;
    assign seq.oACK   = ack_q;
    assign seq.oRDATA = rdata_q;

    assign last_qtr  = (qtr_q == 2'(TICKS_PER_BIT - 1));
    assign last_byte = wr_q ? (byte_q == 2'd2) : (byte_q == 2'd1);

    // Byte currently on the wire: ID (R/W bit forced), SUB, then DATA.
    always_comb begin
        case (byte_q)
            2'd0:    cur_byte = id_byte(wdata_q[23:16], rdph_q);
            2'd1:    cur_byte = wdata_q[15:8];
            default: cur_byte = wdata_q[7:0];
        endcase
    end

    // Bus sequencing: quarter-bit actions and phase transitions, all on ticks.
    always_comb begin
        state_d = state_q;
        qtr_d   = qtr_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        rdph_d  = rdph_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        rx_d    = rx_q;
        scl_d   = scl_q;
        oe_d    = oe_q;
        end_d   = end_q;
        ack_d   = ack_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                scl_d = 1'b1;
                oe_d  = 1'b0;
                end_d = 1'b1;
                if (seq.iGO) begin
                    wr_d    = seq.iWR;
                    wdata_d = seq.iWDATA;
                    ack_d   = 1'b0;
                    end_d   = 1'b0;
                    rdph_d  = 1'b0;
                    byte_d  = 2'd0;
                    qtr_d   = 2'd0;
                    state_d = START;
                end
            end
            DONE: begin
                end_d = 1'b1;
                if (!seq.iGO) begin
                    state_d = IDLE;
                end
            end
            default: begin
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    case (state_q)
                        START: begin
                            if (qtr_q == 2'd0) begin
                                scl_d = 1'b1;
                                oe_d  = 1'b0;
                            end
                            if (qtr_q == 2'd1) oe_d = 1'b1;
                            if (last_qtr) begin
                                scl_d   = 1'b0;
                                bit_d   = 3'(BITS_PER_BYTE - 1);
                                state_d = TXBIT;
                            end
                        end
                        TXBIT, TXACK, RXBIT, RXNACK: begin
                            // Only TX data bits pull SDA; ACK, RX and master NACK slots release it.
                            if (qtr_q == 2'd0) oe_d = (state_q == TXBIT) && !cur_byte[bit_q];
                            if (qtr_q == 2'd1) scl_d = 1'b1;
                            if (qtr_q == 2'd2) begin
                                if (state_q == TXACK && sda_s_q) ack_d = 1'b1;
                                if (state_q == RXBIT) rx_d = {rx_q[6:0], sda_s_q};
                            end
                            if (last_qtr) begin
                                scl_d = 1'b0;
                                case (state_q)
                                    TXBIT, RXBIT: begin
                                        if (bit_q == 3'd0) begin
                                            state_d = (state_q == TXBIT) ? TXACK : RXNACK;
                                        end else begin
                                            bit_d = bit_q - 3'd1;
                                        end
                                    end
                                    TXACK: begin
                                        bit_d = 3'(BITS_PER_BYTE - 1);
                                        if (rdph_q) begin
                                            state_d = RXBIT;
                                        end else if (last_byte) begin
                                            state_d = STOP;
                                        end else begin
                                            byte_d  = byte_q + 2'd1;
                                            state_d = TXBIT;
                                        end
                                    end
                                    default: state_d = STOP;
                                endcase
                            end
                        end
                        STOP: begin
                            if (qtr_q == 2'd0) oe_d = 1'b1;
                            if (qtr_q == 2'd1) scl_d = 1'b1;
                            if (last_qtr) begin
                                oe_d = 1'b0;
                                if (!wr_q && !rdph_q) begin
                                    state_d = GAP;
                                end else begin
                                    state_d = DONE;
                                    end_d   = 1'b1;
                                    if (rdph_q) rdata_d = rx_q;
                                end
                            end
                        end
                        GAP: begin
                            if (last_qtr) begin
                                rdph_d  = 1'b1;
                                byte_d  = 2'd0;
                                state_d = START;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    // State and datapath registers; reset idles the bus without a STOP.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= IDLE;
            qtr_q   <= 2'd0;
            bit_q   <= 3'd0;
            byte_q  <= 2'd0;
            rdph_q  <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= 24'h0;
            rx_q    <= 8'h00;
            scl_q   <= 1'b1;
            oe_q    <= 1'b0;
            end_q   <= 1'b1;
            ack_q   <= 1'b0;
            rdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            qtr_q   <= qtr_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            rdph_q  <= rdph_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            rx_q    <= rx_d;
            scl_q   <= scl_d;
            oe_q    <= oe_d;
            end_q   <= end_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
        end
    end

    // Two-flop synchronizer on the incoming SDA level.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            sda_meta_q <= 1'b1;
            sda_s_q    <= 1'b1;
        end else begin
            sda_meta_q <= I2C_SDAT;
            sda_s_q    <= sda_meta_q;
        end
    end

endmodule

// File: tb/tb_sccb_master.sv
// Bench for sccb_master: SCCB slave model plus bus decoder, expected bus events queued per transfer.
// Latency: write transfers are expected to keep oEND low for 116 quarter-bit ticks.
// Backpressure: the bench plays the sequencer, holding iGO until oEND rises.
module tb_sccb_master;

    localparam int CLK_FREQ  = 25_000_000;
    localparam int SCCB_FREQ = 100_000;
    localparam int QDIV      = CLK_FREQ / (4 * SCCB_FREQ);
    localparam int WR_CYC    = 116 * QDIV;
    localparam int EV_BYTE   = 32'h100;
    localparam int EV_ACK    = 32'h200;
    localparam int EV_START  = 32'h300;
    localparam int EV_STOP   = 32'h400;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    wire  scl;
    wire  sdat;
    logic slave_drv = 1'b0;

    sccb_master_if seq ();

    sccb_master #(
        .CLK_FREQ  (CLK_FREQ),
        .SCCB_FREQ (SCCB_FREQ)
    ) dut (
        .iCLK     (clk),
        .iRST_N   (rst_n),
        .seq      (seq),
        .I2C_SCLK (scl),
        .I2C_SDAT (sdat)
    );

    pullup (sdat);
    assign sdat = slave_drv ? 1'b0 : 1'bz;

    always #20 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];
    int obs[$];
    int rd_idx = 0;

    // Slave behaviour, set by the scenarios.
    int         nack_idx = -1;
    logic [7:0] rd_val   = 8'h00;

    // Slave model and bus decoder.
    int         s_bits = 0;
    int         s_byte = 0;
    logic [7:0] s_sh   = 8'h00;
    logic       s_rd   = 1'b0;
    logic       p_scl  = 1'b1;
    logic       p_sda  = 1'b1;

    always @(scl or sdat or rst_n) begin
        if (!rst_n) begin
            slave_drv = 1'b0;
            s_bits = 0;
            s_byte = 0;
            s_rd   = 1'b0;
        end else if (scl && p_scl && p_sda && !sdat) begin
            obs.push_back(EV_START);
            s_bits = 0;
            s_byte = 0;
            s_rd   = 1'b0;
            slave_drv = 1'b0;
        end else if (scl && p_scl && !p_sda && sdat) begin
            obs.push_back(EV_STOP);
        end else if (scl && !p_scl) begin
            if (s_bits < 8) begin
                s_sh = {s_sh[6:0], sdat};
                s_bits++;
                if (s_bits == 8) begin
                    obs.push_back(EV_BYTE | int'(s_sh));
                    if (s_byte == 0) s_rd = s_sh[0];
                end
            end else begin
                obs.push_back(EV_ACK | int'(sdat));
                s_bits = 0;
                s_byte++;
            end
        end else if (!scl && p_scl) begin
            if (s_rd && s_byte == 1) begin
                slave_drv = (s_bits < 8) ? !rd_val[3'(7 - s_bits)] : 1'b0;
            end else begin
                slave_drv = (s_bits == 8) && (s_byte != nack_idx);
            end
        end
        p_scl = scl;
        p_sda = sdat;
    end

    // SCL high/low period monitor.
    int   scl_err  = 0;
    int   scl_run  = 0;
    logic scl_prev = 1'b1;
    logic armed    = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            scl_run = 0;
            armed   = 1'b0;
        end else if (scl !== scl_prev) begin
            if (armed && scl_run < 2 * QDIV) scl_err++;
            armed   = 1'b1;
            scl_run = 1;
        end else begin
            scl_run++;
        end
        scl_prev = scl;
    end

    function automatic int obs_at(input int idx);
        return (idx < obs.size()) ? obs[idx] : -1;
    endfunction

    task automatic exp_start();
        exp_q.push_back(EV_START);
    endtask

    task automatic exp_stop();
        exp_q.push_back(EV_STOP);
    endtask

    task automatic exp_byte(input logic [7:0] b, input logic a);
        exp_q.push_back(EV_BYTE | int'(b));
        exp_q.push_back(EV_ACK | int'(a));
    endtask

    task automatic exp_write(input logic [23:0] d, input int nack);
        exp_start();
        exp_byte({d[23:17], 1'b0}, nack == 0);
        exp_byte(d[15:8], nack == 1);
        exp_byte(d[7:0], nack == 2);
        exp_stop();
    endtask

    // Sequencer request; counts cycles with oEND low, scrambling iWR/iWDATA mid-transfer.
    task automatic run_xfer(input logic wr, input logic [23:0] d, input bit drop,
                            output int low, output bit to);
        low = 0;
        to  = 1'b0;
        @(negedge clk);
        seq.iGO    = 1'b1;
        seq.iWR    = wr;
        seq.iWDATA = d;
        @(negedge clk);
        seq.iWR    = ~wr;
        seq.iWDATA = ~d;
        while (seq.oEND === 1'b0 && low < 20000) begin
            low++;
            @(negedge clk);
        end
        if (low >= 20000) to = 1'b1;
        if (drop) seq.iGO = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++; if (scl !== 1'b1) begin n_bad++; $display("FAIL reset_scl: got %b want 1", scl); end
        n_cmp++; if (sdat !== 1'b1) begin n_bad++; $display("FAIL reset_sda: got %b want 1 (released)", sdat); end
        n_cmp++; if (seq.oEND !== 1'b1) begin n_bad++; $display("FAIL reset_end: got %b want 1", seq.oEND); end
        n_cmp++; if (seq.oACK !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %b want 0", seq.oACK); end
        n_cmp++; if (seq.oRDATA !== 8'h00) begin n_bad++; $display("FAIL reset_rdata: got %h want 00", seq.oRDATA); end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_write_ack();
        int low; bit to; int e; int o;
        nack_idx = -1;
        exp_write(24'h42_12_80, -1);
        run_xfer(1'b1, 24'h42_12_80, 1'b1, low, to);
        n_cmp++; if (to || low < WR_CYC - QDIV || low > WR_CYC + QDIV) begin
            n_bad++; $display("FAIL wr_ack_len: got %0d cycles (timeout=%0d) want %0d", low, to, WR_CYC); end
        n_cmp++; if (seq.oACK !== 1'b0) begin n_bad++; $display("FAIL wr_ack_flag: got %b want 0", seq.oACK); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_at(rd_idx); rd_idx++;
            n_cmp++; if (o !== e) begin n_bad++; $display("FAIL wr_ack_bus: got %0h want %0h", o, e); end
        end
        n_cmp++; if (obs.size() != rd_idx) begin n_bad++; $display("FAIL wr_ack_extra: got %0d events want %0d", obs.size(), rd_idx); end
        rd_idx = obs.size();
        n_cmp++; if (scl_err !== 0) begin n_bad++; $display("FAIL wr_ack_scl_period: got %0d short periods want 0", scl_err); end
    endtask

    task automatic test_write_nack();
        int low; bit to; int e; int o;
        nack_idx = 2;
        exp_write(24'h42_12_80, 2);
        run_xfer(1'b1, 24'h42_12_80, 1'b1, low, to);
        n_cmp++; if (to || low < WR_CYC - QDIV || low > WR_CYC + QDIV) begin
            n_bad++; $display("FAIL wr_nack_len: got %0d cycles (timeout=%0d) want %0d", low, to, WR_CYC); end
        n_cmp++; if (seq.oACK !== 1'b1) begin n_bad++; $display("FAIL wr_nack_flag: got %b want 1", seq.oACK); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_at(rd_idx); rd_idx++;
            n_cmp++; if (o !== e) begin n_bad++; $display("FAIL wr_nack_bus: got %0h want %0h", o, e); end
        end
        n_cmp++; if (obs.size() != rd_idx) begin n_bad++; $display("FAIL wr_nack_extra: got %0d events want %0d", obs.size(), rd_idx); end
        rd_idx = obs.size();
        nack_idx = -1;
    endtask

    task automatic test_read();
        int low; bit to; int e; int o;
        nack_idx = -1;
        rd_val   = 8'h76;
        exp_start(); exp_byte(8'h42, 1'b0); exp_byte(8'h0A, 1'b0); exp_stop();
        exp_start(); exp_byte(8'h43, 1'b0); exp_byte(8'h76, 1'b1); exp_stop();
        run_xfer(1'b0, 24'h42_0A_5A, 1'b1, low, to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL rd_timeout: got %0d cycles want completion", low); end
        n_cmp++; if (seq.oRDATA !== 8'h76) begin n_bad++; $display("FAIL rd_data: got %h want 76", seq.oRDATA); end
        n_cmp++; if (seq.oACK !== 1'b0) begin n_bad++; $display("FAIL rd_ack_flag: got %b want 0", seq.oACK); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_at(rd_idx); rd_idx++;
            n_cmp++; if (o !== e) begin n_bad++; $display("FAIL rd_bus: got %0h want %0h", o, e); end
        end
        n_cmp++; if (obs.size() != rd_idx) begin n_bad++; $display("FAIL rd_extra: got %0d events want %0d", obs.size(), rd_idx); end
        rd_idx = obs.size();
        n_cmp++; if (scl_err !== 0) begin n_bad++; $display("FAIL rd_scl_period: got %0d short periods want 0", scl_err); end
    endtask

    task automatic test_back_to_back();
        int low; bit to; int e; int o; int busy;
        nack_idx = -1;
        exp_write(24'h42_12_80, -1);
        run_xfer(1'b1, 24'h42_12_80, 1'b0, low, to);
        busy = 0;
        repeat (10000) begin
            @(negedge clk);
            if (seq.oEND !== 1'b1) busy++;
        end
        n_cmp++; if (busy != 0) begin n_bad++; $display("FAIL hold_end: got %0d busy cycles want 0", busy); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_at(rd_idx); rd_idx++;
            n_cmp++; if (o !== e) begin n_bad++; $display("FAIL hold_bus: got %0h want %0h", o, e); end
        end
        n_cmp++; if (obs.size() != rd_idx) begin n_bad++; $display("FAIL hold_retrigger: got %0d events want %0d", obs.size(), rd_idx); end
        rd_idx = obs.size();
        seq.iGO = 1'b0;
        repeat (3) @(negedge clk);
        exp_write(24'h42_3A_04, -1);
        run_xfer(1'b1, 24'h42_3A_04, 1'b1, low, to);
        n_cmp++; if (to || low < WR_CYC - QDIV || low > WR_CYC + QDIV) begin
            n_bad++; $display("FAIL b2b_len: got %0d cycles (timeout=%0d) want %0d", low, to, WR_CYC); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_at(rd_idx); rd_idx++;
            n_cmp++; if (o !== e) begin n_bad++; $display("FAIL b2b_bus: got %0h want %0h", o, e); end
        end
        n_cmp++; if (obs.size() != rd_idx) begin n_bad++; $display("FAIL b2b_extra: got %0d events want %0d", obs.size(), rd_idx); end
        rd_idx = obs.size();
    endtask

    task automatic test_reset_mid();
        int low; bit to; int e; int o; int w;
        nack_idx = 0;
        @(negedge clk);
        seq.iGO    = 1'b1;
        seq.iWR    = 1'b1;
        seq.iWDATA = 24'h42_12_80;
        w = 0;
        while (obs.size() < rd_idx + 3 && w < 5000) begin
            w++;
            @(negedge clk);
        end
        n_cmp++; if (w >= 5000) begin n_bad++; $display("FAIL rstmid_id_wait: got %0d events want %0d", obs.size() - rd_idx, 3); end
        repeat (3 * 4 * QDIV) @(negedge clk);
        n_cmp++; if (seq.oACK !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre_ack: got %b want 1", seq.oACK); end
        #7;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (scl !== 1'b1) begin n_bad++; $display("FAIL rstmid_scl: got %b want 1", scl); end
        n_cmp++; if (sdat !== 1'b1) begin n_bad++; $display("FAIL rstmid_sda: got %b want 1 (released)", sdat); end
        n_cmp++; if (seq.oEND !== 1'b1) begin n_bad++; $display("FAIL rstmid_end: got %b want 1", seq.oEND); end
        n_cmp++; if (seq.oACK !== 1'b0) begin n_bad++; $display("FAIL rstmid_ack: got %b want 0", seq.oACK); end
        seq.iGO = 1'b0;
        nack_idx = -1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        rd_idx = obs.size();
        exp_write(24'h42_12_80, -1);
        run_xfer(1'b1, 24'h42_12_80, 1'b1, low, to);
        n_cmp++; if (to || low < WR_CYC - QDIV || low > WR_CYC + QDIV) begin
            n_bad++; $display("FAIL rstmid_len: got %0d cycles (timeout=%0d) want %0d", low, to, WR_CYC); end
        n_cmp++; if (seq.oACK !== 1'b0) begin n_bad++; $display("FAIL rstmid_post_ack: got %b want 0", seq.oACK); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_at(rd_idx); rd_idx++;
            n_cmp++; if (o !== e) begin n_bad++; $display("FAIL rstmid_bus: got %0h want %0h", o, e); end
        end
        n_cmp++; if (obs.size() != rd_idx) begin n_bad++; $display("FAIL rstmid_extra: got %0d events want %0d", obs.size(), rd_idx); end
        rd_idx = obs.size();
    endtask

    initial begin
        seq.iGO    = 1'b0;
        seq.iWR    = 1'b0;
        seq.iWDATA = 24'h0;
        test_reset();
        test_write_ack();
        test_write_nack();
        test_read();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
